sync_fifo_wr_arb: RTL
=====================

// Module: sync_fifo_wr_arb
// PURPOSE
//  Round-robin write arbiter sharing one sync_fifo write port between NREQ producers.
//  Grants one requester at a time for a burst of up to BURST beats and forwards its data.
//  Honours FIFO back-pressure via full. Sits directly in front of sync_fifo (wr_en/wr_data/full).
// PARAMETERS
//  NREQ    4  number of requesters (>=2)
//  BITWID  5  data width, equal to the sync_fifo BITWID
//  BURST   4  max accepted beats per grant (>=1)
// PORTS
//  clk       in   1             clock, rising edge
//  rst_n     in   1             asynchronous active-low reset
//  req       in   NREQ          per-requester write request, held until ack or withdrawn
//  req_data  in   NREQ*BITWID   requester i data on bits [i*BITWID +: BITWID]
//  ack       out  NREQ          one-hot beat accepted this cycle (comb)
//  gnt       out  NREQ          one-hot current grant (registered)
//  gnt_id    out  clog2(NREQ)   index of granted requester, valid while busy
//  busy      out  1             a grant is active (state GRANT)
//  full      in   1             sync_fifo full
//  wr_en     out  1             sync_fifo write enable (comb)
//  wr_data   out  BITWID        sync_fifo write data (comb mux of req_data[gnt_id])
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, gnt_id=0, busy=0, beat_cnt=0, rr_ptr=0; ack=0, wr_en=0.
//  Reset is asynchronous at any time, including mid-burst: the grant is dropped at once and no
//   further writes occur. Priority restarts at requester 0.
//  FSM (2 states):
//   - IDLE: if |req, pick the first requester with req=1 scanning rr_ptr, rr_ptr+1, .. mod NREQ.
//     Next cycle: GRANT, gnt/gnt_id set, beat_cnt=0. No write is issued in IDLE.
//     Every grant is therefore preceded by one bubble cycle.
//   - GRANT: accept = req[gnt_id] & ~full.
//     wr_en = ack[gnt_id] = accept; wr_data = req_data[gnt_id]; other ack bits 0.
//     Accepted beat with beat_cnt==BURST-1 -> IDLE, rr_ptr=gnt_id+1 mod NREQ.
//     Accepted beat otherwise -> beat_cnt+1, stay in GRANT.
//     req[gnt_id]==0 -> IDLE, rr_ptr=gnt_id+1 mod NREQ (withdrawal ends the burst, no write).
//     full==1 with req held -> stall: stay in GRANT, beat_cnt unchanged, no timeout.
//  Latency: req rise in IDLE -> gnt next cycle -> first write that cycle if ~full (1 bubble).
//  Ordering: data of one requester reaches the FIFO in its presentation order; no beat is
//   dropped or duplicated; exactly one write per ack.
//  Fairness: with all requesters active, grants rotate 0,1,..,NREQ-1,0; a lone requester is
//   re-granted after one IDLE bubble.
//  Width: beat_cnt is clog2(BURST) bits (min 1); rr_ptr/gnt_id wrap NREQ-1 -> 0 explicitly,
//   including non-power-of-2 NREQ.
//  req_data is sampled combinationally; the requester must hold data stable while req=1 and
//   ack=0.
// STRUCTURE
//  Package fifo_arb_pkg: state enum {IDLE, GRANT}; clog2-based width constants for gnt_id
//   and beat_cnt.
//  Sub-module rr_pick (comb): inputs req, rr_ptr; outputs any, idx (rotating priority encoder).
//  Top holds the FSM, rr_ptr, beat_cnt, gnt registers and the data mux.
// TESTING (NREQ=4, BITWID=5, BURST=4, sync_fifo DEEPWID=3)
//  Setup: sync_fifo is 8 deep with rd_en=1 for scenarios 1, 3 and 4.
//  1 All req=1, requester i data = 4i+beat -> FIFO receives 0..3, 4..7, 8..11, 12..15.
//    One idle cycle between bursts; gnt_id runs 0,1,2,3,0.
//  2 rd_en=0, only req[1]=1 for 12 beats -> 8 writes, then full=1.
//    ack stays 0 while full; beat_cnt frozen; after rd_en=1 the remaining beats drain in order.
//  3 req[2] drops after 2 accepted beats, req[3]=1 -> IDLE then grant 3.
//    Exactly 2 writes from requester 2.
//  4 Only req[0]=1 continuously -> grant 0 repeatedly.
//    Pattern per 5 cycles: 1 bubble + 4 writes.
//  5 rst_n=0 mid-burst (beat 2 of requester 1) -> gnt=0, wr_en=0 immediately.
//    After release with all req=1, first grant is requester 0.
//  Checker: scoreboard comparing per-requester queues against FIFO rd_data.
//   Asserts $onehot0(gnt), $onehot0(ack), and wr_en implies ~full.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the sync_fifo write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   clog2_min1  : index/counter width that never collapses to zero bits
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // A single requester or a one-beat burst still needs a 1-bit register.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Widths for the default configuration (NREQ=4, BURST=4).
    localparam int unsigned DefIdW  = clog2_min1(4);
    localparam int unsigned DefCntW = clog2_min1(4);

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder.
//   req    : request vector
//   rr_ptr : requester with highest priority this cycle (must be < NREQ)
//   any    : at least one request is set
//   idx    : first set request scanning rr_ptr, rr_ptr+1, .. wrapping at NREQ
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    int unsigned cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // rr_ptr < NREQ, so one subtraction is enough to wrap (also for non-power-of-2 NREQ)
            cand = 32'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand[IDW-1:0]]) begin
                any = 1'b1;
                idx = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync_fifo write port between NREQ producers.
// A grant lasts up to BURST accepted beats; every grant is preceded by one IDLE cycle.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req        : per-requester write request
//   req_data   : requester i data on bits [i*BITWID +: BITWID]
//   ack        : one-hot, beat accepted this cycle (combinational)
//   gnt        : one-hot current grant (registered)
//   gnt_id     : index of the granted requester, valid while busy
//   busy       : a grant is active
//   full       : sync_fifo full
//   wr_en      : sync_fifo write enable (combinational)
//   wr_data    : sync_fifo write data, req_data of the granted requester
module sync_fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned BITWID = 5,
    parameter  int unsigned BURST  = 4,
    localparam int unsigned IDW    = clog2_min1(NREQ),
    localparam int unsigned CNTW   = clog2_min1(BURST)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BITWID-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          gnt,
    output logic [IDW-1:0]           gnt_id,
    output logic                     busy,
    input  logic                     full,
    output logic                     wr_en,
    output logic [BITWID-1:0]        wr_data
);

    arb_state_e      state;
    logic [CNTW-1:0] beat_cnt;
    logic [IDW-1:0]  rr_ptr;

    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic            accept;
    logic            last_beat;
    logic [IDW-1:0]  next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign busy      = (state == GRANT);
    assign accept    = busy & req[gnt_id] & ~full;
    assign last_beat = (beat_cnt == CNTW'(BURST - 1));
    assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    assign wr_en = accept;
    // gnt is one-hot on gnt_id while busy, so it doubles as the ack mask.
    assign ack   = accept ? gnt : '0;

    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                wr_data = req_data[i*BITWID +: BITWID];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        gnt      <= NREQ'(1) << pick_idx;
                        gnt_id   <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || (accept && last_beat)) begin
                        // Withdrawal or a full burst hands priority to the next requester.
                        state  <= IDLE;
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNTW'(1);
                    end
                    // full with req held: stall, nothing changes
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
